keypad_scan_fifo: RTL and testbench

Upstream input stage for the float23 adder-subtractor UI: scans the 4x4 keypad matrix, debounces, and encodes each press to a 4-bit hex nibble. Presses are queued in a small FIFO, and the UI editing logic pops them with a valid/ready handshake. This replaces free-running PRESSED/NXTVAL sampling with a single-clock-domain, lossless key stream plus an overrun flag.

---
 rtl/keypad_scan_fifo.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad scanner: column scan, per-sweep debounce FSM, hex encoding and a key FIFO.
// Optional auto-repeat of a held key is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_fifo #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE     = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 15
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [3:0]                    KEYPAD_ROWS,
    output logic [3:0]                    KEYPAD_COLS,
    output logic                          KEY_VALID,
    output logic [3:0]                    KEY_VAL,
    input  logic                          KEY_READY,
    output logic                          KEY_HELD,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERRUN,
    input  logic                          CLR_OVERRUN,
    output logic [1:0]                    DBG_STATE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0]    DEB_N    = 8'(DEBOUNCE);
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

    // Out-of-range parameters elaborate a named marker block visible in the hierarchy.
    if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 255 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    end

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } state_e;

    logic [3:0]    rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [15:0]   work_q, work_d;
    logic [15:0]   snap_q, snap_d;
    logic          sweep_q, sweep_d;
    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          held_q, held_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d;

    logic [4:0]    bit_cnt;
    logic [3:0]    hit_idx;
    logic          is_none, is_single;
    logic          fsm_push, rep_push, push_all;
    logic [3:0]    push_val;
    logic          pop, full, wr_en, ovr_set;

    function automatic logic [3:0] encode(input logic [3:0] idx);
        logic [3:0] e;
        case (idx)
            4'd0:  e = 4'h1;
            4'd1:  e = 4'h2;
            4'd2:  e = 4'h3;
            4'd3:  e = 4'hA;
            4'd4:  e = 4'h4;
            4'd5:  e = 4'h5;
            4'd6:  e = 4'h6;
            4'd7:  e = 4'hB;
            4'd8:  e = 4'h7;
            4'd9:  e = 4'h8;
            4'd10: e = 4'h9;
            4'd11: e = 4'hC;
            4'd12: e = 4'hE;
            4'd13: e = 4'h0;
            4'd14: e = 4'hF;
            default: e = 4'hD;
        endcase
        return e;
    endfunction

    // Column scan: rows are sampled on the last dwell cycle, after the synchronizer settles.
    always_comb begin
        rows_s1_d = KEYPAD_ROWS;
        rows_s2_d = rows_s1_q;
        div_d     = div_q + DW'(1);
        col_d     = col_q;
        work_d    = work_q;
        snap_d    = snap_q;
        sweep_d   = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            col_d = col_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                work_d[{2'(r), col_q}] = ~rows_s2_q[r];
            end
            if (col_q == 2'd3) begin
                snap_d  = work_d;
                sweep_d = 1'b1;
            end
        end
    end

    always_comb begin
        bit_cnt = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_q[i]) begin
                bit_cnt = bit_cnt + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign is_none   = (bit_cnt == 5'd0);
    assign is_single = (bit_cnt == 5'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        held_d   = held_q;
        fsm_push = 1'b0;
        if (sweep_q) begin
            case (state_q)
                RELEASED: begin
                    if (is_single) begin
                        key_d   = hit_idx;
                        cnt_d   = 8'd1;
                        state_d = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (is_single) begin
                        if (hit_idx == key_q) begin
                            cnt_d = cnt_q + 8'd1;
                        end else begin
                            key_d = hit_idx;
                            cnt_d = 8'd1;
                        end
                    end else begin
                        state_d = RELEASED;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        cnt_d   = 8'd1;
                        state_d = RELEASE_DEB;
                    end
                end
                default: begin
                    if (is_none) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
            // Threshold checks follow the move so DEBOUNCE=1 accepts on the very first sweep.
            if (state_d == PRESS_DEB && cnt_d == DEB_N) begin
                fsm_push = 1'b1;
                held_d   = 1'b1;
                state_d  = HELD;
            end
            if (state_d == RELEASE_DEB && cnt_d == DEB_N) begin
                held_d  = 1'b0;
                state_d = RELEASED;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0] rep_q, rep_d;
    logic        armed_q, armed_d;

    always_comb begin
        rep_d    = rep_q;
        armed_d  = armed_q;
        rep_push = 1'b0;
        if (sweep_q) begin
            if (state_q == HELD && is_single && hit_idx == key_q) begin
                rep_d = rep_q + 16'd1;
                if (!armed_q && rep_d == 16'(REPEAT_DELAY)) begin
                    rep_push = 1'b1;
                    rep_d    = '0;
                    armed_d  = 1'b1;
                end else if (armed_q && rep_d == 16'(REPEAT_RATE)) begin
                    rep_push = 1'b1;
                    rep_d    = '0;
                end
            end else begin
                rep_d   = '0;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            armed_q <= armed_d;
        end
    end
`else
    assign rep_push = 1'b0;
`endif

    assign push_all = fsm_push | rep_push;
    assign push_val = fsm_push ? encode(hit_idx) : encode(key_q);

    // Handshake: the head transfers on any cycle where KEY_VALID && KEY_READY; the head
    // and KEY_VAL hold still otherwise. A push into a full FIFO survives only if a pop coincides.
    always_comb begin
        pop     = (count_q != '0) && KEY_READY;
        full    = (count_q == FULL_CNT);
        wr_en   = push_all && (!full || pop);
        ovr_set = push_all && full && !pop;
        mem_d   = mem_q;
        if (wr_en) begin
            mem_d[wr_q] = push_val;
        end
        wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        ovr_d = ovr_set ? 1'b1 : (CLR_OVERRUN ? 1'b0 : ovr_q);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
            div_q     <= '0;
            col_q     <= '0;
            work_q    <= '0;
            snap_q    <= '0;
            sweep_q   <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            key_q     <= '0;
            held_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rows_s1_q <= rows_s1_d;
            rows_s2_q <= rows_s2_d;
            div_q     <= div_d;
            col_q     <= col_d;
            work_q    <= work_d;
            snap_q    <= snap_d;
            sweep_q   <= sweep_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            held_q    <= held_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            mem_q     <= mem_d;
        end
    end

    assign KEYPAD_COLS = ~(4'b0001 << col_q);
    assign KEY_VALID   = (count_q != '0);
    assign KEY_VAL     = mem_q[rd_q];
    assign KEY_HELD    = held_q;
    assign FIFO_COUNT  = count_q;
    assign OVERRUN     = ovr_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: keypad matrix model, sweep-level reference model with an
// expected FIFO queue, per-cycle output comparison, directed scenarios and random sweeps.
module tb_keypad_scan_fifo;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int SWEEP      = 4 * SCAN_DIV;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] KEYPAD_ROWS;
    logic [3:0] KEYPAD_COLS;
    logic       KEY_VALID;
    logic [3:0] KEY_VAL;
    logic       KEY_READY = 1'b0;
    logic       KEY_HELD;
    logic [2:0] FIFO_COUNT;
    logic       OVERRUN;
    logic       CLR_OVERRUN = 1'b0;
    logic [1:0] DBG_STATE;

    always #5 CLK = ~CLK;

    keypad_scan_fifo #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE   (DEBOUNCE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .REPEAT_DELAY(50),
        .REPEAT_RATE(15)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .KEYPAD_ROWS (KEYPAD_ROWS),
        .KEYPAD_COLS (KEYPAD_COLS),
        .KEY_VALID   (KEY_VALID),
        .KEY_VAL     (KEY_VAL),
        .KEY_READY   (KEY_READY),
        .KEY_HELD    (KEY_HELD),
        .FIFO_COUNT  (FIFO_COUNT),
        .OVERRUN     (OVERRUN),
        .CLR_OVERRUN (CLR_OVERRUN),
        .DBG_STATE   (DBG_STATE)
    );

    // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
    logic [15:0] pressed = '0;
    always_comb begin
        KEYPAD_ROWS = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !KEYPAD_COLS[c]) KEYPAD_ROWS[r] = 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [3:0] enc_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] exp_q[$];
    int         hist[$];
    int         cyc;
    bit         model_on = 1'b0;
    bit         m_ovr, m_held, m_held_next, pend_push;
    logic [3:0] pend_val;

    task automatic model_reset();
        cyc = -1;
        exp_q.delete();
        hist.delete();
        m_ovr = 0;
        m_held = 0;
        m_held_next = 0;
        pend_push = 0;
        pend_val = '0;
    endtask

    always @(posedge CLK) begin : model_blk
        bit do_pop, was_full, ovr_set, all_same;
        int code, nbits;
        if (model_on) begin
            cyc++;
            was_full = (exp_q.size() == FIFO_DEPTH);
            do_pop   = (exp_q.size() != 0) && KEY_READY;
            if (do_pop) void'(exp_q.pop_front());
            ovr_set = 0;
            if (pend_push) begin
                if (!was_full || do_pop) exp_q.push_back(pend_val);
                else ovr_set = 1;
            end
            if (ovr_set) m_ovr = 1;
            else if (CLR_OVERRUN) m_ovr = 0;
            m_held    = m_held_next;
            pend_push = 0;
            if (cyc % SWEEP == SWEEP - 1) begin
                nbits = $countones(pressed);
                code  = (nbits == 0) ? -1 : -2;
                if (nbits == 1) for (int i = 0; i < 16; i++) if (pressed[i]) code = i;
                hist.push_back(code);
                if (hist.size() > DEBOUNCE) void'(hist.pop_front());
                if (hist.size() == DEBOUNCE) begin
                    all_same = 1;
                    foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
                    if (all_same && !m_held_next && hist[0] >= 0) begin
                        pend_push   = 1;
                        pend_val    = enc_tab[hist[0]];
                        m_held_next = 1;
                    end else if (all_same && m_held_next && hist[0] == -1) begin
                        m_held_next = 0;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin : compare_blk
        logic [3:0] exp_cols;
        if (model_on && RESET_N) begin
            exp_cols = ~(4'b0001 << (((cyc + 1) / SCAN_DIV) % 4));
            check("key_valid", KEY_VALID, exp_q.size() != 0);
            if (exp_q.size() != 0) check("key_val", KEY_VAL, exp_q[0]);
            check("fifo_count", FIFO_COUNT, exp_q.size());
            check("overrun", OVERRUN, m_ovr);
            check("key_held", KEY_HELD, m_held);
            check("keypad_cols", KEYPAD_COLS, exp_cols);
        end
    end

    logic [3:0] got_q[$];
    int first_valid_cyc = -1;
    always @(posedge CLK) if (RESET_N && KEY_VALID && KEY_READY) got_q.push_back(KEY_VAL);
    always @(negedge CLK) if (model_on && KEY_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;

    // rmode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the first cycle.
    task automatic run_sweeps(input logic [15:0] keys, input int n, input int rmode, input bit clr);
        pressed = keys;
        for (int i = 0; i < n * SWEEP; i++) begin
            case (rmode)
                0: KEY_READY = 1'b0;
                1: KEY_READY = 1'b1;
                2: KEY_READY = 1'($urandom_range(0, 1));
                default: KEY_READY = (i == 0);
            endcase
            CLR_OVERRUN = clr;
            @(negedge CLK);
        end
        KEY_READY = 1'b0;
        CLR_OVERRUN = 1'b0;
    endtask

    task automatic press(input int idx);
        run_sweeps(16'(1) << idx, DEBOUNCE + 1, 0, 0);
        run_sweeps('0, DEBOUNCE + 1, 0, 0);
    endtask

    task automatic drain();
        run_sweeps('0, 1, 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols"}, KEYPAD_COLS, 4'b1110);
        check({tag, "_valid"}, KEY_VALID, 0);
        check({tag, "_val"}, KEY_VAL, 0);
        check({tag, "_held"}, KEY_HELD, 0);
        check({tag, "_count"}, FIFO_COUNT, 0);
        check({tag, "_overrun"}, OVERRUN, 0);
        check({tag, "_state"}, DBG_STATE, 0);
    endtask

    initial begin : main
        logic [3:0] exp_order [4] = '{4'h3, 4'hA, 4'h0, 4'hF};
        logic [15:0] keys;
        int pick, n, rmode, a, b;

        model_reset();
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        model_on = 1'b1;

        // Key 6 held five sweeps, no consumer.
        run_sweeps(16'(1) << 6, 5, 0, 0);
        check("k6_held", KEY_HELD, 1);
        check("k6_count", FIFO_COUNT, 1);
        check("k6_val", KEY_VAL, 4'h6);
        check("k6_valid_latency", first_valid_cyc, 3 * SWEEP);
        run_sweeps('0, 4, 0, 0);
        check("k6_released", KEY_HELD, 0);
        drain();
        check("k6_drained", FIFO_COUNT, 0);

        // Bouncing key 1.
        run_sweeps(16'h0001, 1, 0, 0);
        run_sweeps('0, 1, 0, 0);
        run_sweeps(16'h0001, 3, 0, 0);
        check("bounce_no_push_yet", FIFO_COUNT, 0);
        run_sweeps('0, 4, 0, 0);
        check("bounce_count", FIFO_COUNT, 1);
        check("bounce_val", KEY_VAL, 4'h1);
        drain();

        // Five presses into a four-entry FIFO.
        press(2); press(3); press(13); press(14); press(15);
        check("fill_count", FIFO_COUNT, 4);
        check("fill_overrun", OVERRUN, 1);
        check("fill_head", KEY_VAL, 4'h3);
        got_q.delete();
        drain();
        check("pop_total", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check("pop_order", (i < got_q.size()) ? int'(got_q[i]) : -1, exp_order[i]);
        check("pop_empty", KEY_VALID, 0);
        run_sweeps('0, 1, 0, 1);
        check("clr_overrun", OVERRUN, 0);

        // Full FIFO with a pop on the push cycle.
        press(0); press(1); press(4); press(5);
        run_sweeps(16'(1) << 8, DEBOUNCE, 0, 0);
        run_sweeps(16'(1) << 8, 1, 3, 0);
        run_sweeps('0, 4, 0, 0);
        check("fullpop_count", FIFO_COUNT, 4);
        check("fullpop_overrun", OVERRUN, 0);
        check("fullpop_head", KEY_VAL, 4'h2);
        drain();

        // Two keys together are ignored; one alone is accepted.
        run_sweeps((16'(1) << 12) | (16'(1) << 15), 4, 0, 0);
        check("multi_count", FIFO_COUNT, 0);
        check("multi_state", DBG_STATE, 0);
        check("multi_held", KEY_HELD, 0);
        press(12);
        check("star_val", KEY_VAL, 4'hE);
        check("star_count", FIFO_COUNT, 1);
        drain();

        // Reset mid-sweep with entries queued and a key mid-debounce.
        press(0); press(1);
        run_sweeps(16'(1) << 10, 1, 0, 0);
        repeat (5) @(negedge CLK);
        #2;
        model_on = 1'b0;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge CLK);
        model_reset();
        RESET_N = 1'b1;
        model_on = 1'b1;
        press(10);
        check("after_rst_val", KEY_VAL, 4'h9);
        check("after_rst_count", FIFO_COUNT, 1);
        drain();

        // Random sweeps.
        for (int it = 0; it < 60; it++) begin
            pick  = $urandom_range(0, 9);
            rmode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            if (pick < 5) begin
                keys = 16'(1) << $urandom_range(0, 15);
                n = $urandom_range(1, 5);
            end else if (pick < 8) begin
                keys = '0;
                n = $urandom_range(1, 4);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                keys = (16'(1) << a) | (16'(1) << b);
                n = $urandom_range(1, 2);
            end
            run_sweeps(keys, n, rmode, ($urandom_range(0, 5) == 0));
        end
        run_sweeps('0, 4, 2, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
